perf_dump_sched: RTL and testbench

Frame scheduler for the cache-event performance monitor. It snapshots the flattened event-counter bank on a periodic timer or a manual trigger and issues a one-cycle clear to the counters. It then serialises the snapshot byte-by-byte into the UART TX FIFO as a framed packet: header, sequence number, counter bytes and an optional checksum. It sits between the counter bank and the TX FIFO write port and is the only writer of that FIFO.

---
 rtl/perf_dump_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_perf_dump_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_dump_sched.sv
// -----------------------------------------------------------------------------
// perf_dump_sched
//
// Frame scheduler for the cache-event performance monitor. It snapshots the
// flattened counter bank on a periodic timer tick or a manual request, clears
// the bank for one cycle, and then writes the snapshot into the UART TX FIFO
// one byte at a time as a framed packet:
//   HDR, seq+1, counter 0 (MSB byte first) .. counter NUM_CNT-1 [, checksum]
//
// Optional feature macro: DUMP_CHECKSUM_EN
//   When defined, an 8-bit XOR of the SEQ and DATA bytes follows the data.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cnt_i        counter bank, counter k at [k*CNT_W +: CNT_W]
//   start_i      manual dump request (level, sampled every cycle)
//   fifo_full_i  TX FIFO full
//   fifo_wr_en_o FIFO write strobe (combinational: emit state and not full)
//   fifo_data_o  FIFO write data (0 outside emit states)
//   clr_o        one-cycle counter-bank clear (high in the snapshot cycle)
//   busy_o       frame in progress
//   drop_o       one-cycle pulse: a trigger arrived while busy and was lost
//   seq_o        sequence number of the last completed frame
// -----------------------------------------------------------------------------
module perf_dump_sched #(
  parameter int         NUM_CNT = 8,
  parameter int         CNT_W   = 16,
  parameter int         PERIOD  = 1024,
  parameter logic [7:0] HDR     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_i,
  input  logic                     start_i,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [7:0]               fifo_data_o,
  output logic                     clr_o,
  output logic                     busy_o,
  output logic                     drop_o,
  output logic [7:0]               seq_o
);

  localparam int TOTAL_W     = NUM_CNT * CNT_W;
  localparam int TOTAL_BYTES = TOTAL_W / 8;
  localparam int IDX_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam int TMR_W       = $clog2(PERIOD);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SNAP = 3'd1,
    S_HDR  = 3'd2,
    S_SEQ  = 3'd3,
    S_DATA = 3'd4
`ifdef DUMP_CHECKSUM_EN
    ,
    S_CHK  = 3'd5
`endif
  } state_t;

  state_t             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TOTAL_W-1:0] shadow_q;
  logic [7:0]         seq_q;
  logic               clr_q;
  logic               drop_q;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]         acc_q;
`endif

  logic               timer_tick_s;
  logic               trig_s;
  logic               emit_s;
  logic               wr_s;
  logic [7:0]         data_s;
  logic [7:0]         seq_d;
  logic [TOTAL_W-1:0] stream_d;

  assign timer_tick_s = (timer_q == TMR_LAST);
  assign trig_s       = timer_tick_s | start_i;
  assign seq_d        = seq_q + 8'd1;

  // Free-running dump timer; it keeps counting while a frame is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= {TMR_W{1'b0}};
    end else if (timer_tick_s) begin
      timer_q <= {TMR_W{1'b0}};
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Reorder the bank into transmit order (counter 0 in the top bits) so the
  // shadow only ever has to shift left and present its top byte.
  always_comb begin
    stream_d = {TOTAL_W{1'b0}};
    for (int k = 0; k < NUM_CNT; k++) begin
      stream_d[(NUM_CNT-1-k)*CNT_W +: CNT_W] = cnt_i[k*CNT_W +: CNT_W];
    end
  end

  // Byte selection for the current emit state; data is a pure function of
  // registered state, so it holds unchanged while the FIFO is full.
  always_comb begin
    emit_s = 1'b0;
    data_s = 8'h00;
    case (state_q)
      S_HDR: begin
        emit_s = 1'b1;
        data_s = HDR;
      end
      S_SEQ: begin
        emit_s = 1'b1;
        data_s = seq_d;
      end
      S_DATA: begin
        emit_s = 1'b1;
        data_s = shadow_q[TOTAL_W-1 -: 8];
      end
`ifdef DUMP_CHECKSUM_EN
      S_CHK: begin
        emit_s = 1'b1;
        data_s = acc_q;
      end
`endif
      default: begin
        emit_s = 1'b0;
        data_s = 8'h00;
      end
    endcase
  end

  assign wr_s = emit_s & ~fifo_full_i;

  // Frame sequencer: snapshot, header, sequence byte, data bytes, checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= {IDX_W{1'b0}};
      shadow_q <= {TOTAL_W{1'b0}};
      seq_q    <= 8'h00;
      clr_q    <= 1'b0;
      drop_q   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc_q    <= 8'h00;
`endif
    end else begin
      clr_q  <= 1'b0;
      // Any trigger outside IDLE is lost, including one in the finishing cycle.
      drop_q <= trig_s && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (trig_s) begin
            state_q <= S_SNAP;
            clr_q   <= 1'b1;
          end
        end
        S_SNAP: begin
          shadow_q <= stream_d;
          idx_q    <= {IDX_W{1'b0}};
`ifdef DUMP_CHECKSUM_EN
          acc_q    <= 8'h00;
`endif
          state_q  <= S_HDR;
        end
        S_HDR: begin
          if (wr_s) begin
            state_q <= S_SEQ;
          end
        end
        S_SEQ: begin
          if (wr_s) begin
`ifdef DUMP_CHECKSUM_EN
            acc_q   <= acc_q ^ data_s;
`endif
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (wr_s) begin
            shadow_q <= shadow_q << 8;
`ifdef DUMP_CHECKSUM_EN
            acc_q    <= acc_q ^ data_s;
`endif
            if (idx_q == LAST_IDX) begin
              idx_q   <= {IDX_W{1'b0}};
`ifdef DUMP_CHECKSUM_EN
              state_q <= S_CHK;
`else
              seq_q   <= seq_d;
              state_q <= S_IDLE;
`endif
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CHK: begin
          if (wr_s) begin
            seq_q   <= seq_d;
            state_q <= S_IDLE;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_wr_en_o = wr_s;
  assign fifo_data_o  = data_s;
  assign clr_o        = clr_q;
  assign drop_o       = drop_q;
  assign busy_o       = (state_q != S_IDLE);
  assign seq_o        = seq_q;

endmodule

// File: tb/tb_perf_dump_sched.sv
`timescale 1ns/1ps
module tb_perf_dump_sched;

  localparam int         NUM_CNT = 2;
  localparam int         CNT_W   = 16;
  localparam int         PERIOD  = 64;
  localparam logic [7:0] HDR     = 8'hA5;
  localparam int         NBYTES  = NUM_CNT * CNT_W / 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int         FRAME_LEN = NBYTES + 3;
`else
  localparam int         FRAME_LEN = NBYTES + 2;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CNT*CNT_W-1:0] cnt_i;
  logic                     start_i;
  logic                     fifo_full_i;
  logic                     fifo_wr_en_o;
  logic [7:0]               fifo_data_o;
  logic                     clr_o;
  logic                     busy_o;
  logic                     drop_o;
  logic [7:0]               seq_o;

  always #5 clk = ~clk;

  perf_dump_sched #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W),
    .PERIOD  (PERIOD),
    .HDR     (HDR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt_i        (cnt_i),
    .start_i      (start_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .clr_o        (clr_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o),
    .seq_o        (seq_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of bytes still to be written.
  int         m_cyc;
  bit         m_busy;
  bit         m_snap;
  bit         m_drop;
  logic [7:0] m_seq;
  logic [7:0] m_bytes[$];
  int         m_frames;

  // Observation bookkeeping (DUT outputs seen at negedge).
  logic [7:0] obs_q[$];
  int         clr_cyc_q[$];
  int         n_clr, n_drop, n_busy;
  logic [7:0] last_data;

  function automatic void model_reset();
    m_cyc  = 0;
    m_busy = 1'b0;
    m_snap = 1'b0;
    m_drop = 1'b0;
    m_seq  = 8'h00;
    m_bytes.delete();
  endfunction

  // One clock cycle: compare at negedge, advance the model at posedge.
  task automatic step();
    bit         trig;
    logic [7:0] ck;
    logic [7:0] b;
    logic [7:0] e_data;
    @(negedge clk);
    e_data = (m_busy && !m_snap && m_bytes.size() > 0) ? m_bytes[0] : 8'h00;
    check_eq("busy", busy_o, m_busy);
    check_eq("clr", clr_o, m_busy && m_snap);
    check_eq("wr_en", fifo_wr_en_o, m_busy && !m_snap && !fifo_full_i);
    check_eq("data", fifo_data_o, e_data);
    check_eq("drop", drop_o, m_drop);
    check_eq("seq", seq_o, m_seq);
    if (fifo_wr_en_o) obs_q.push_back(fifo_data_o);
    if (clr_o) begin
      n_clr++;
      clr_cyc_q.push_back(m_cyc);
    end
    if (drop_o) n_drop++;
    if (busy_o) n_busy++;
    last_data = fifo_data_o;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      trig   = ((m_cyc % PERIOD) == PERIOD - 1) || start_i;
      m_drop = trig && m_busy;
      if (!m_busy) begin
        if (trig) begin
          m_busy = 1'b1;
          m_snap = 1'b1;
        end
      end else if (m_snap) begin
        m_bytes.delete();
        m_bytes.push_back(HDR);
        ck = m_seq + 8'd1;
        m_bytes.push_back(ck);
        for (int k = 0; k < NUM_CNT; k++) begin
          for (int j = CNT_W/8 - 1; j >= 0; j--) begin
            b = cnt_i[k*CNT_W + j*8 +: 8];
            m_bytes.push_back(b);
            ck = ck ^ b;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        m_bytes.push_back(ck);
`endif
        m_snap = 1'b0;
      end else if (!fifo_full_i) begin
        void'(m_bytes.pop_front());
        if (m_bytes.size() == 0) begin
          m_seq  = m_seq + 8'd1;
          m_busy = 1'b0;
          m_frames++;
        end
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic do_reset();
    start_i     = 1'b0;
    fifo_full_i = 1'b0;
    rst         = 1'b1;
    model_reset();
    #1;
    check_eq("rst_wr_en", fifo_wr_en_o, 1'b0);
    check_eq("rst_data", fifo_data_o, 8'h00);
    check_eq("rst_clr", clr_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_drop", drop_o, 1'b0);
    check_eq("rst_seq", seq_o, 8'h00);
    step();
    step();
    rst = 1'b0;
    n_clr  = 0;
    n_drop = 0;
    n_busy = 0;
    obs_q.delete();
    clr_cyc_q.delete();
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget && m_busy; i++) step();
    check_eq("idle_timeout", busy_o, 1'b0);
  endtask

  logic [7:0] exp1[$];
  logic [7:0] ck1;
  int         n_before;
  bit         cleared;

  initial begin
    cnt_i       = '0;
    start_i     = 1'b0;
    fifo_full_i = 1'b0;
    rst         = 1'b0;
    m_frames    = 0;
    #1;

    // Single manual frame with a fixed bank value.
    do_reset();
    cnt_i = 32'h1234_ABCD;
    exp1 = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h12, 8'h34};
    ck1  = 8'h01 ^ 8'hAB ^ 8'hCD ^ 8'h12 ^ 8'h34;
`ifdef DUMP_CHECKSUM_EN
    exp1.push_back(ck1);
`endif
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_idle(40);
    check_eq("s1_clr_count", n_clr, 1);
    check_eq("s1_len", obs_q.size(), FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++)
      check_eq($sformatf("s1_byte%0d", i), (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp1[i]);
    check_eq("s1_seq", seq_o, 8'd1);
    check_eq("s1_busy_cycles", n_busy, FRAME_LEN + 1);

    // Backpressure: FIFO full for 10 cycles starting at the second write.
    do_reset();
    start_i = 1'b1;
    step();            // IDLE, trigger
    start_i = 1'b0;
    step();            // SNAP
    step();            // HDR written
    fifo_full_i = 1'b1;
    n_before = obs_q.size();
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_hold_data", last_data, 8'h01);
    end
    check_eq("bp_no_write", obs_q.size(), n_before);
    fifo_full_i = 1'b0;
    run_idle(40);
    check_eq("bp_len", obs_q.size(), FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++)
      check_eq($sformatf("bp_byte%0d", i), (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp1[i]);
    check_eq("bp_busy_cycles", n_busy, FRAME_LEN + 1 + 10);

    // Trigger during DATA is dropped.
    do_reset();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (3) step(); // SNAP, HDR, SEQ
    start_i = 1'b1;
    step();            // first DATA byte
    start_i = 1'b0;
    run_idle(40);
    repeat (5) step();
    check_eq("drop_count", n_drop, 1);
    check_eq("drop_clr_count", n_clr, 1);
    check_eq("drop_seq", seq_o, 8'd1);
    check_eq("drop_frames", obs_q.size(), FRAME_LEN);

    // Reset in the middle of a frame, then a fresh frame.
    do_reset();
    cnt_i   = 32'hDEAD_BEEF;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (4) step();
    do_reset();
    cnt_i   = 32'h0BAD_F00D;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_idle(40);
    check_eq("mid_len", obs_q.size(), FRAME_LEN);
    if (obs_q.size() >= 6) begin
      check_eq("mid_seq_byte", obs_q[1], 8'h01);
      check_eq("mid_d0", obs_q[2], 8'hF0);
      check_eq("mid_d1", obs_q[3], 8'h0D);
      check_eq("mid_d2", obs_q[4], 8'h0B);
      check_eq("mid_d3", obs_q[5], 8'hAD);
    end

    // Periodic trigger only.
    do_reset();
    cnt_i = 32'h1234_ABCD;
    repeat (200) step();
    check_eq("per_count", clr_cyc_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("per_start%0d", i),
               (i < clr_cyc_q.size()) ? clr_cyc_q[i] + 1 : 0, 65 + 64 * i);
      check_eq($sformatf("per_seq%0d", i),
               (FRAME_LEN * i + 1 < obs_q.size()) ? obs_q[FRAME_LEN * i + 1] : 8'hxx, i + 1);
    end

    // Sequence wrap over 256 frames.
    do_reset();
    m_frames = 0;
    cleared  = 1'b0;
    for (int i = 0; i < 256 * (FRAME_LEN + 3) + 400 && m_frames < 256; i++) begin
      cnt_i   = $urandom;
      start_i = !m_busy;
      step();
      if (m_frames == 255 && !cleared) begin
        obs_q.delete();
        cleared = 1'b1;
      end
    end
    start_i = 1'b0;
    check_eq("wrap_clr_count", n_clr, 256);
    check_eq("wrap_seq_o", seq_o, 8'h00);
    check_eq("wrap_len", obs_q.size(), FRAME_LEN);
    check_eq("wrap_seq_byte", (obs_q.size() > 1) ? obs_q[1] : 8'hxx, 8'h00);

    // Randomized traffic, backpressure and occasional reset.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cnt_i       = $urandom;
      start_i     = ($urandom_range(0, 5) == 0);
      fifo_full_i = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
